// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART: bit-sequencer states, the MMIO window
// addresses and the word returned when a load finds the RX queue empty.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [31:0] UART_TX_ADDR  = 32'h0000_0400;
    localparam logic [31:0] UART_RX_ADDR  = 32'h0000_0404;
    localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Synchronous FIFO with a combinational head output. A push into a full FIFO
// and a pop from an empty FIFO are both ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_q[rd_ptr_q];

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO UART engine: TX/RX FIFOs, baud counters and bit-sequencing FSMs.
// Define UART_LOOPBACK_EN to feed the receiver from the internal transmitter.
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_req,
    input  logic [7:0]  tx_byte,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_overflow,
    output logic        rx_overflow,
    output logic        rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic          uart_tx_q, uart_tx_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_ferr_q, rx_ferr_d;
    logic          rx_meta_q, rx_sync_q, rx_src_s;
    logic          tx_pop_s, tx_full_s, tx_empty_s, rx_push_s, rx_full_s, rx_empty_s;
    logic [7:0]    tx_dout_s, rx_dout_s;

`ifdef UART_LOOPBACK_EN
    logic unused_uart_rx_s;
    assign unused_uart_rx_s = uart_rx;
    assign rx_src_s         = uart_tx_q;
`else
    assign rx_src_s = uart_rx;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(send_req), .pop(tx_pop_s),
        .din(tx_byte), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_s), .pop(rd_en),
        .din(rx_shift_q), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
    );

    assign rd_data      = rx_empty_s ? RX_EMPTY_WORD : {24'h00_0000, rx_dout_s};
    assign uart_tx      = uart_tx_q;
    assign tx_busy      = ~tx_empty_s | (tx_state_q != IDLE);
    assign tx_overflow  = tx_ovf_q;
    assign rx_overflow  = rx_ovf_q;
    assign rx_frame_err = rx_ferr_q;

    // TX sequencer: the line level for the next cycle is decided here so uart_tx is a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        uart_tx_d  = uart_tx_q;
        tx_pop_s   = 1'b0;
        tx_ovf_d   = tx_ovf_q | (send_req & tx_full_s);
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d  = '0;
                uart_tx_d = 1'b1;
                if (!tx_empty_s) begin
                    tx_state_d = START;
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_dout_s;
                    uart_tx_d  = 1'b0;
                end else begin
                    tx_state_d = IDLE;
                end
            end
            START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    uart_tx_d  = tx_shift_q[0];
                end else begin
                    tx_state_d = START;
                end
            end
            DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                        uart_tx_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        uart_tx_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_state_d = DATA;
                end
            end
            STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next frame so back-to-back bytes have no idle gap.
                    if (!tx_empty_s) begin
                        tx_state_d = START;
                        tx_pop_s   = 1'b1;
                        tx_shift_d = tx_dout_s;
                        uart_tx_d  = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                    end
                end else begin
                    tx_state_d = STOP;
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
                uart_tx_d  = 1'b1;
            end
        endcase
    end

    // RX sequencer: start bit is confirmed at half a bit, later bits sampled one bit apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_s  = 1'b0;
        rx_ovf_d   = rx_ovf_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = START;
                else            rx_state_d = IDLE;
            end
            START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    rx_state_d = START;
                end
            end
            DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                    else                  rx_state_d = DATA;
                end else begin
                    rx_state_d = DATA;
                end
            end
            STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (!rx_sync_q)     rx_ferr_d = 1'b1;
                    else if (rx_full_s) rx_ovf_d  = 1'b1;
                    else                rx_push_s = 1'b1;
                end else begin
                    rx_state_d = STOP;
                end
            end
            default: begin
                rx_state_d = IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    // State, counter, synchronizer and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            uart_tx_q  <= 1'b1;
            tx_ovf_q   <= 1'b0;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_ovf_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_meta_q  <= rx_src_s;
            rx_sync_q  <= rx_meta_q;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl (CLKS_PER_BIT=8, FIFO_DEPTH=4); TX bytes are
// decoded off uart_tx, RX bytes are driven serially and read back through rd_en.
module tb_uart_mmio_ctrl;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam logic [31:0] EMPTY_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_req = 1'b0;
    logic [7:0]  tx_byte = 8'h00;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        uart_rx = 1'b1;
    logic        uart_tx, tx_busy, tx_overflow, rx_overflow, rx_frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    logic mon_en = 1'b1;
    logic exp_tx_ovf = 1'b0, exp_rx_ovf = 1'b0, exp_ferr = 1'b0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int tx_start_q[$];

    uart_mmio_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .send_req(send_req), .tx_byte(tx_byte),
        .rd_en(rd_en), .rd_data(rd_data), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_busy(tx_busy), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Serial decoder: mid-bit sampling of every frame seen on uart_tx.
    always begin
        logic [7:0] b;
        @(negedge clk);
        if (mon_en && rst_n && uart_tx === 1'b0) begin
            tx_start_q.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check_eq("tx_stop", {31'h0, uart_tx}, 32'h1);
            if (tx_exp_q.size() == 0) check_eq("tx_extra", {24'h0, b}, 32'hDEAD);
            else                      check_eq("tx_byte", {24'h0, b}, {24'h0, tx_exp_q.pop_front()});
        end
    end

    task automatic tx_send(input logic [7:0] b);
        @(negedge clk);
        send_req = 1'b1;
        tx_byte  = b;
        tx_exp_q.push_back(b);
`ifdef UART_LOOPBACK_EN
        rx_exp_q.push_back(b);
`endif
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_v);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_v;
        if (!stop_v)                        exp_ferr = 1'b1;
        else if (rx_exp_q.size() >= DEPTH)  exp_rx_ovf = 1'b1;
        else                                rx_exp_q.push_back(d);
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        logic [31:0] exp;
        @(negedge clk);
        rd_en = 1'b1;
        #1;
        exp = (rx_exp_q.size() > 0) ? {24'h0, rx_exp_q.pop_front()} : EMPTY_W;
        check_eq(tag, rd_data, exp);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_tx_idle(input int max_cyc);
        int n = 0;
        while ((tx_exp_q.size() != 0 || tx_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_drain_timeout", {31'h0, (n >= max_cyc)}, 32'h0);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_txovf"}, {31'h0, tx_overflow}, {31'h0, exp_tx_ovf});
        check_eq({tag, "_rxovf"}, {31'h0, rx_overflow}, {31'h0, exp_rx_ovf});
        check_eq({tag, "_ferr"},  {31'h0, rx_frame_err}, {31'h0, exp_ferr});
    endtask

    task automatic test_tx_wave();
        logic [7:0] pat = 8'hA5;
        logic [7:0] v, e;
        tx_send(pat);
        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                v[s] = uart_tx;
            end
            if (p == 0)      e = 8'h00;
            else if (p == 9) e = 8'hFF;
            else             e = pat[p-1] ? 8'hFF : 8'h00;
            check_eq($sformatf("t1_period%0d", p), {24'h0, v}, {24'h0, e});
        end
        check_eq("t1_busy_at80", {31'h0, tx_busy}, 32'h1);
        @(negedge clk);
        check_eq("t1_busy_at81", {31'h0, tx_busy}, 32'h0);
        wait_tx_idle(200);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check_eq("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        check_eq("rst_rd_data", rd_data, EMPTY_W);
        check_flags("rst");

        test_tx_wave();

`ifndef UART_LOOPBACK_EN
        // RX byte then an empty read
        rx_frame(8'h3C, 1'b1);
        do_read("t2_rd0");
        do_read("t2_rd1");

        // TX FIFO fill and overflow, frames back-to-back
        tx_start_q.delete();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            send_req = 1'b1;
            tx_byte  = 8'(i);
            tx_exp_q.push_back(8'(i));
        end
        @(negedge clk);
        check_eq("t3_ovf_after5", {31'h0, tx_overflow}, 32'h0);
        tx_byte = 8'h06;
        @(negedge clk);
        send_req   = 1'b0;
        exp_tx_ovf = 1'b1;
        check_eq("t3_ovf_after6", {31'h0, tx_overflow}, 32'h1);
        wait_tx_idle(800);
        check_eq("t3_frames", tx_start_q.size(), 32'd5);
        for (int i = 1; i < tx_start_q.size(); i++)
            check_eq($sformatf("t3_gap%0d", i), tx_start_q[i] - tx_start_q[i-1], 32'd80);

        // Bad stop bit, then a short glitch
        rx_frame(8'hA7, 1'b0);
        check_flags("t4_ferr");
        do_read("t4_rd_after_ferr");
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        do_read("t4_rd_after_glitch");

        // RX overflow
        for (int i = 1; i <= 5; i++) rx_frame(8'(8'h11 * i), 1'b1);
        check_flags("t5_ovf");
        for (int i = 0; i < 5; i++) do_read($sformatf("t5_rd%0d", i));
`endif

        // Reset in the middle of a frame
        mon_en = 1'b0;
        tx_send(8'h00);
        tx_send(8'h00);
        tx_send(8'h00);
        tx_exp_q.delete();
        rx_exp_q.delete();
        repeat (26) @(negedge clk);
        check_eq("t6_midframe_tx", {31'h0, uart_tx}, 32'h0);
        check_flags("t6_pre");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_tx_ovf = 1'b0;
        exp_rx_ovf = 1'b0;
        exp_ferr   = 1'b0;
        check_eq("t6_tx_high", {31'h0, uart_tx}, 32'h1);
        check_eq("t6_busy", {31'h0, tx_busy}, 32'h0);
        check_eq("t6_rd", rd_data, EMPTY_W);
        check_flags("t6_post");
        repeat (100) @(negedge clk);
        check_eq("t6_tx_stays_high", {31'h0, uart_tx}, 32'h1);
        mon_en = 1'b1;

`ifdef UART_LOOPBACK_EN
        tx_send(8'h5A);
        wait_tx_idle(200);
        do_read("t6_loop_rd0");
        do_read("t6_loop_rd1");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
